// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : bundles the fetch port, the data port, the unified-memory port and
//           the busy flag of mem_arbiter into one interface.
// Modports:
//   master - the arbiter's view: takes fetch/data requests and memory
//            responses, drives completions, the memory request and busy.
//   slave  - the environment's view (requesters plus memory): the mirror image.
// Signals :
//   i_req/i_addr -> i_rdata/i_valid                   instruction fetch port
//   d_req/d_we/d_addr/d_wdata/d_wmask -> d_rdata/d_valid   load/store port
//   mem_req/mem_addr/mem_wdata/mem_wmask/mem_we <- mem_gnt/mem_rvalid/mem_rdata
//   busy                                              arbiter not idle
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  // data port
  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wmask;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_valid;
  // unified memory port
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_we;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  // status
  logic busy;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_valid,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_rdata, d_valid,
    output mem_req, mem_addr, mem_wdata, mem_wmask, mem_we,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_valid,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_rdata, d_valid,
    input  mem_req, mem_addr, mem_wdata, mem_wmask, mem_we,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Purpose : shares one single-outstanding unified memory port between an
//           instruction-fetch requester and a load/store requester.
// Ports   :
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_arbiter_if.master (fetch port, data port, memory port, busy)
// Config  :
//   MEM_ARB_RR_EN undefined - data requester wins whenever both are pending.
//   MEM_ARB_RR_EN defined   - round-robin between the two requesters based on
//                             who was captured last (reset: fetch).
// Flow    : IDLE -> I_REQ/D_REQ (mem_req held until mem_gnt) -> I_WAIT/D_WAIT
//           (reads only, until mem_rvalid) -> RESP (one valid pulse) -> IDLE.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] I_REQ  = 3'd1;
  localparam logic [2:0] D_REQ  = 3'd2;
  localparam logic [2:0] I_WAIT = 3'd3;
  localparam logic [2:0] D_WAIT = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  logic [2:0]          state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wmask_q, mem_wmask_d;
  logic                mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                i_valid_q,   i_valid_d;
  logic                d_valid_q,   d_valid_d;
  // 1 = the transaction in flight belongs to the data port
  logic                owner_q,     owner_d;

  logic pick_data;   // selection made in IDLE when at least one req is up
  logic finish;      // transaction completes this cycle, RESP follows
  logic take_rdata;  // mem_rdata is the response for the transaction in flight

`ifdef MEM_ARB_RR_EN
  // 1 = data port was captured last; reset value points at fetch so the first
  // contended pick goes to data
  logic last_data_q, last_data_d;

  // With both pending, grant whoever was not captured last; a lone request
  // is always granted.
  assign pick_data = bus.d_req & (~bus.i_req | ~last_data_q);
`else
  assign pick_data = bus.d_req;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    mem_we_d    = mem_we_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    owner_d     = owner_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    finish      = 1'b0;
    take_rdata  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.i_req) begin
          mem_req_d = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_data_d = pick_data;
`endif
          if (pick_data) begin
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_wmask_d = bus.d_wmask;
            mem_we_d    = bus.d_we;
            owner_d     = 1'b1;
            state_d     = D_REQ;
          end else begin
            // fetches never write: clear the store-only fields
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
            mem_we_d    = 1'b0;
            owner_d     = 1'b0;
            state_d     = I_REQ;
          end
        end
      end

      I_REQ, D_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            // stores complete on acceptance, no read response expected
            finish = 1'b1;
          end else if (bus.mem_rvalid) begin
            // zero-wait memory: response alongside the grant
            take_rdata = 1'b1;
            finish     = 1'b1;
          end else begin
            state_d = owner_q ? D_WAIT : I_WAIT;
          end
        end
      end

      I_WAIT, D_WAIT: begin
        if (bus.mem_rvalid) begin
          take_rdata = 1'b1;
          finish     = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (take_rdata) begin
      if (owner_q) d_rdata_d = bus.mem_rdata;
      else         i_rdata_d = bus.mem_rdata;
    end

    // valid registers are loaded on the edge into RESP, so they are high
    // exactly for the RESP cycle
    if (finish) begin
      state_d   = RESP;
      d_valid_d = owner_q;
      i_valid_d = ~owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_we_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      owner_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_we_q    <= mem_we_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      owner_q     <= owner_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: reset values, fetch with delayed response,
// store with delayed grant, zero-wait load, stray rvalid, requester dropping
// req, reset during D_WAIT, and contended arbitration order (order expected
// depends on MEM_ARB_RR_EN).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.d_wmask    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0b want=0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0b want=0", bus.mem_we); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 68'h0) begin bad++; $display("FAIL rst_mem_fields addr=%0h wdata=%0h wmask=%0h want=0", bus.mem_addr, bus.mem_wdata, bus.mem_wmask); end
    total++; if ({bus.i_valid, bus.d_valid} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%0b%0b want=00", bus.i_valid, bus.d_valid); end
    total++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata i=%0h d=%0h want=0", bus.i_rdata, bus.d_rdata); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h100}) begin bad++; $display("FAIL fetch_issue req=%0b we=%0b addr=%0h want=1,0,100", bus.mem_req, bus.mem_we, bus.mem_addr); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%0b want=1", bus.busy); end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    total++; if ({bus.mem_req, bus.i_valid} !== 2'b00) begin bad++; $display("FAIL fetch_after_gnt req=%0b i_valid=%0b want=0,0", bus.mem_req, bus.i_valid); end
    step();
    total++; if (bus.i_valid !== 1'b0) begin bad++; $display("FAIL fetch_wait_valid got=%0b want=0", bus.i_valid); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00500093;
    step();
    bus.mem_rvalid = 1'b0;
    bus.i_req      = 1'b0;
    total++; if ({bus.i_valid, bus.d_valid} !== 2'b10) begin bad++; $display("FAIL fetch_valid i=%0b d=%0b want=1,0", bus.i_valid, bus.d_valid); end
    total++; if (bus.i_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%0h want=00500093", bus.i_rdata); end
    $display("txn fetch addr=100 rdata=%0h", bus.i_rdata);
    step();
    total++; if ({bus.i_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL fetch_end i_valid=%0b busy=%0b want=0,0", bus.i_valid, bus.busy); end
    total++; if (bus.i_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_hold got=%0h want=00500093", bus.i_rdata); end
  endtask

  task automatic test_idle_rvalid();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    step();
    bus.mem_rvalid = 1'b0;
    step();
    total++; if ({bus.i_valid, bus.d_valid, bus.busy} !== 3'b000) begin bad++; $display("FAIL stray_rvalid i=%0b d=%0b busy=%0b want=000", bus.i_valid, bus.d_valid, bus.busy); end
    total++; if (bus.i_rdata !== 32'h00500093) begin bad++; $display("FAIL stray_rdata got=%0h want=00500093", bus.i_rdata); end
    $display("txn stray rvalid in IDLE");
  endtask

  task automatic test_store();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_wmask = 4'h3;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.d_valid} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b0}) begin
        bad++;
        $display("FAIL store_hold cyc=%0d req=%0b we=%0b addr=%0h wdata=%0h wmask=%0h d_valid=%0b want=1,1,2000,deadbeef,3,0",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.d_valid);
      end
      if (i < 3) step();
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    bus.d_req   = 1'b0;
    total++; if ({bus.d_valid, bus.i_valid, bus.mem_req} !== 3'b100) begin bad++; $display("FAIL store_done d=%0b i=%0b req=%0b want=1,0,0", bus.d_valid, bus.i_valid, bus.mem_req); end
    $display("txn store addr=2000 wdata=deadbeef wmask=3");
    step();
    total++; if ({bus.d_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL store_end d_valid=%0b busy=%0b want=0,0", bus.d_valid, bus.busy); end
  endtask

  task automatic test_load_fast();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h3000;
    step();
    total++; if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL load_early got=%0b want=0", bus.d_valid); end
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    total++; if ({bus.d_valid, bus.i_valid} !== 2'b10) begin bad++; $display("FAIL load_valid d=%0b i=%0b want=1,0", bus.d_valid, bus.i_valid); end
    total++; if (bus.d_rdata !== 32'h12345678) begin bad++; $display("FAIL load_rdata got=%0h want=12345678", bus.d_rdata); end
    $display("txn load addr=3000 rdata=%0h", bus.d_rdata);
    step();
  endtask

  task automatic test_req_drop();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h200;
    step();
    bus.i_req      = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE0001;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    total++; if ({bus.i_valid, bus.i_rdata} !== {1'b1, 32'hCAFE0001}) begin bad++; $display("FAIL drop_valid i_valid=%0b rdata=%0h want=1,cafe0001", bus.i_valid, bus.i_rdata); end
    $display("txn fetch (req dropped) addr=200 rdata=%0h", bus.i_rdata);
    step();
    total++; if ({bus.i_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL drop_once i_valid=%0b busy=%0b want=0,0", bus.i_valid, bus.busy); end
  endtask

  task automatic test_reset_in_wait();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h5000;
    step();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    total++; if ({bus.busy, bus.d_valid, bus.mem_req} !== 3'b100) begin bad++; $display("FAIL dwait_state busy=%0b d=%0b req=%0b want=1,0,0", bus.busy, bus.d_valid, bus.mem_req); end
    rst = 1'b1;
    step();
    rst            = 1'b0;
    bus.d_req      = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    step();
    bus.mem_rvalid = 1'b0;
    total++; if ({bus.d_valid, bus.i_valid, bus.busy} !== 3'b000) begin bad++; $display("FAIL post_rst_flags d=%0b i=%0b busy=%0b want=000", bus.d_valid, bus.i_valid, bus.busy); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== 34'h0) begin bad++; $display("FAIL post_rst_mem req=%0b we=%0b addr=%0h want=0", bus.mem_req, bus.mem_we, bus.mem_addr); end
    total++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("FAIL post_rst_rdata i=%0h d=%0h want=0", bus.i_rdata, bus.d_rdata); end
    $display("txn reset during D_WAIT, late rvalid dropped");
  endtask

  // Waits for the next capture, checks which requester won, answers with a
  // zero-wait read and checks the matching completion.
  task automatic run_one(input logic [31:0] exp_addr, input logic exp_data, input logic [31:0] rd);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL arb_timeout mem_req=%0b want=1", bus.mem_req); end
    total++; if (bus.mem_addr !== exp_addr) begin bad++; $display("FAIL arb_order addr=%0h want=%0h", bus.mem_addr, exp_addr); end
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    total++; if ({bus.d_valid, bus.i_valid} !== {exp_data, ~exp_data}) begin bad++; $display("FAIL arb_valid d=%0b i=%0b want=%0b,%0b", bus.d_valid, bus.i_valid, exp_data, ~exp_data); end
    total++; if ((exp_data ? bus.d_rdata : bus.i_rdata) !== rd) begin bad++; $display("FAIL arb_rdata got=%0h want=%0h", exp_data ? bus.d_rdata : bus.i_rdata, rd); end
    $display("txn arb %s addr=%0h rdata=%0h", exp_data ? "data " : "fetch", exp_addr, rd);
  endtask

  task automatic test_arbitration();
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h1000;
    bus.d_req  = 1'b1;
    bus.i_addr = 32'h400;
    bus.i_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
    run_one(32'h1000, 1'b1, 32'hA1);
    bus.d_addr = 32'h1004;
    run_one(32'h400, 1'b0, 32'hB1);
    bus.i_req = 1'b0;
    run_one(32'h1004, 1'b1, 32'hA2);
    bus.d_req = 1'b0;
`else
    run_one(32'h1000, 1'b1, 32'hA1);
    bus.d_addr = 32'h1004;
    run_one(32'h1004, 1'b1, 32'hA2);
    bus.d_req = 1'b0;
    run_one(32'h400, 1'b0, 32'hB1);
    bus.i_req = 1'b0;
`endif
    step();
    step();
    total++; if ({bus.busy, bus.mem_req} !== 2'b00) begin bad++; $display("FAIL arb_end busy=%0b req=%0b want=0,0", bus.busy, bus.mem_req); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_idle_rvalid();
    test_store();
    test_load_fast();
    test_req_drop();
    test_reset_in_wait();
    test_arbitration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports; mask width is DATA_W/8.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  fetch request; held with i_addr stable until i_valid.
REQ-006 i_addr  in  ADDR_W  fetch address.
REQ-007 i_rdata  out  DATA_W  fetched instruction, meaningful when i_valid=1.
REQ-008 i_valid  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wmask stable until d_valid.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr, d_wdata  in  ADDR_W, DATA_W  data address and store data.
REQ-012 d_wmask  in  DATA_W/8  byte-enable for stores.
REQ-013 d_rdata  out  DATA_W  load data, meaningful when d_valid=1.
REQ-014 d_valid  out  1  one-cycle completion pulse for loads and stores.
REQ-015 mem_req  out  1  unified-memory request, registered.
REQ-016 mem_addr, mem_wdata, mem_wmask, mem_we  out  ADDR_W, DATA_W, DATA_W/8, 1  registered request fields.
REQ-017 mem_gnt  in  1  memory accepts request in cycle mem_req & mem_gnt.
REQ-018 mem_rvalid, mem_rdata  in  1, DATA_W  read response.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, I_REQ, D_REQ, I_WAIT, D_WAIT, RESP; one transaction outstanding at a time.
REQ-021 IDLE: on pending request, capture address/fields of the selected requester into registers, go to I_REQ or D_REQ; mem_req=1 from the next cycle.
REQ-022 Both requests pending in IDLE: selection per REQ-033/034.
REQ-023 X_REQ: hold mem_req and fields stable until mem_gnt; no timeout.
REQ-024 Store granted (mem_gnt, mem_we=1): deassert mem_req next cycle, go RESP, pulse d_valid for exactly one cycle.
REQ-025 Load/fetch granted: deassert mem_req next cycle, go X_WAIT; wait indefinitely for mem_rvalid.
REQ-026 mem_rvalid in the same cycle as mem_gnt for a read: treated as completion, skip X_WAIT.
REQ-027 On completion, register mem_rdata into i_rdata or d_rdata and pulse the matching valid in RESP; RESP -> IDLE next cycle.
REQ-028 Minimum latency request-to-valid: 3 cycles (IDLE capture, REQ with gnt and rvalid, RESP).
REQ-029 mem_rvalid outside X_REQ/X_WAIT: ignored.
REQ-030 Requester deasserting req mid-transaction: transaction completes, valid still pulses once.
REQ-031 i_rdata/d_rdata hold last returned value between pulses; never both valids high in one cycle.

Reset
REQ-032 rst: state=IDLE, mem_req=0, mem_we=0, all mem fields=0, i_valid=d_valid=0, i_rdata=d_rdata=0, busy=0, last-grant=fetch; any in-flight response arriving after rst is ignored.

Configuration
REQ-033 Macro MEM_ARB_RR_EN undefined: fixed priority, data wins over fetch whenever both pending in IDLE.
REQ-034 MEM_ARB_RR_EN defined: round-robin; both pending grants the requester not granted last; last-grant register updated on every capture; single pending request always granted immediately.

Verification
REQ-035 Fetch i_addr=0x100, mem_gnt immediate, rvalid 2 cycles later with 0x00500093 -> i_valid one pulse, i_rdata=0x00500093, busy low afterwards.
REQ-036 Store d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=0x3, gnt delayed 4 cycles -> mem_req held 4 cycles with stable fields, d_valid pulses 1 cycle after gnt, no i_valid.
REQ-037 i_req and d_req both asserted in same IDLE cycle, twice back-to-back -> without macro: D,D,I order; with MEM_ARB_RR_EN: D then I, alternating.
REQ-038 Load with gnt and rvalid same cycle, rdata=0x12345678 -> d_valid at cycle 3, d_rdata=0x12345678.
REQ-039 rst asserted in D_WAIT, then mem_rvalid=1 after rst release -> no d_valid, state IDLE, all outputs at reset values.
